// File: rtl/ds_temp_sched.sv
// ds_temp_sched: autonomous DS18B20 temperature sampler on top of ds_intf_byte.
//
// Sequence per sample:
//   bus reset, skip ROM (CC), convert T (44), conversion wait, bus reset, skip ROM (CC),
//   read scratchpad (BE), read N bytes, [terminating bus reset], publish result.
//
// Configuration macro: DS_SCRATCH_CRC_EN
//   defined   : read all 9 scratchpad bytes and require a zero Dallas CRC8 residue.
//   undefined : read only the 2 temperature bytes, then abort the read with a bus reset.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   auto_en                    level, enables periodic sampling every PERIOD_CYC cycles
//   start                      pulse, request one sample
//   intf_rst_en/wr_en/rd_en    one-cycle command strobes to the byte interface
//   intf_wdata                 command byte for intf_wr_en
//   intf_rdata, intf_rdata_vld read byte and its one-cycle valid
//   intf_rdy                   byte interface idle
//   temp_raw/abs/neg           latest good sample (raw two's complement, magnitude, sign)
//   temp_vld                   pulse, temp_* updated this cycle
//   busy                       sequence in progress
//   err                        pulse, sample discarded (no device or bad CRC)
module ds_temp_sched #(
    parameter int unsigned PERIOD_CYC = 50_000_000,
    parameter int unsigned CONV_CYC   = 37_500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        auto_en,
    input  logic        start,
    output logic        intf_rst_en,
    output logic        intf_wr_en,
    output logic [7:0]  intf_wdata,
    output logic        intf_rd_en,
    input  logic [7:0]  intf_rdata,
    input  logic        intf_rdata_vld,
    input  logic        intf_rdy,
    output logic [15:0] temp_raw,
    output logic [11:0] temp_abs,
    output logic        temp_neg,
    output logic        temp_vld,
    output logic        busy,
    output logic        err
);

`ifdef DS_SCRATCH_CRC_EN
    localparam int unsigned NBYTES = 9;
`else
    localparam int unsigned NBYTES = 2;
`endif

    localparam logic [31:0] PERIOD_LAST = 32'(PERIOD_CYC - 1);
    localparam logic [31:0] CONV_LAST   = 32'(CONV_CYC - 1);
    localparam logic [3:0]  LAST_BYTE   = 4'(NBYTES - 1);

    typedef enum logic [3:0] {
        StIdle,
        StRst1,
        StSkip1,
        StConv,
        StWaitConv,
        StRst2,
        StSkip2,
        StRdsp,
        StRead,
        StTerm,
        StDone
    } state_e;

    // Handshake phase inside every command state.
    typedef enum logic [1:0] {
        PhIssue,
        PhGuard,
        PhWait
    } phase_e;

    state_e      state_q, state_d;
    phase_e      phase_q, phase_d;
    logic [31:0] period_cnt_q, period_cnt_d;
    logic [31:0] conv_cnt_q, conv_cnt_d;
    logic        pending_q, pending_d;
    logic [3:0]  rd_cnt_q, rd_cnt_d;
    logic [3:0]  byte_idx_q, byte_idx_d;
    logic [7:0]  lsb_q, lsb_d;
    logic [7:0]  msb_q, msb_d;
    logic        ok_q, ok_d;
    logic [15:0] temp_raw_q, temp_raw_d;
    logic [11:0] temp_abs_q, temp_abs_d;
    logic        temp_neg_q, temp_neg_d;

    logic        cmd_state;
    logic        cmd_issue;
    logic        cmd_done;
    logic        load;
    logic        sample_ok;
    logic        period_trig;

`ifdef DS_SCRATCH_CRC_EN
    logic [7:0]  crc_q, crc_d;

    // Dallas CRC8, reflected polynomial 0x8C, data LSB first.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ 8'h8C;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction
`endif

    // Trigger path: periodic counter plus one-deep pending request.
    always_comb begin
        period_cnt_d = period_cnt_q;
        period_trig  = 1'b0;
        pending_d    = pending_q;
        if (!auto_en) begin
            period_cnt_d = '0;
        end else if (period_cnt_q == PERIOD_LAST) begin
            period_cnt_d = '0;
            period_trig  = 1'b1;
        end else begin
            period_cnt_d = period_cnt_q + 32'd1;
        end
        if (state_q == StIdle && pending_q) begin
            pending_d = 1'b0;
        end
        // A new trigger wins over consumption so it is never lost.
        if (start || period_trig) begin
            pending_d = 1'b1;
        end
    end

    always_comb begin
        cmd_state = 1'b0;
        unique case (state_q)
            StRst1, StSkip1, StConv, StRst2, StSkip2, StRdsp, StRead, StTerm: cmd_state = 1'b1;
            default: cmd_state = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        conv_cnt_d = conv_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        byte_idx_d = byte_idx_q;
        lsb_d      = lsb_q;
        msb_d      = msb_q;
        ok_d       = ok_q;
        temp_raw_d = temp_raw_q;
        temp_abs_d = temp_abs_q;
        temp_neg_d = temp_neg_q;
        cmd_issue  = 1'b0;
        cmd_done   = 1'b0;
        load       = 1'b0;
`ifdef DS_SCRATCH_CRC_EN
        crc_d      = crc_q;
`endif

        // Issue only with rdy, ignore rdy for one guard cycle, then complete on rdy.
        if (cmd_state) begin
            unique case (phase_q)
                PhIssue: begin
                    if (intf_rdy) begin
                        cmd_issue = 1'b1;
                        phase_d   = PhGuard;
                    end
                end
                PhGuard: phase_d = PhWait;
                PhWait: begin
                    if (intf_rdy) begin
                        cmd_done = 1'b1;
                        phase_d  = PhIssue;
                    end
                end
                default: phase_d = PhIssue;
            endcase
        end

        if (state_q == StRead && intf_rdata_vld) begin
            if (byte_idx_q == 4'd0) lsb_d = intf_rdata;
            if (byte_idx_q == 4'd1) msb_d = intf_rdata;
            byte_idx_d = byte_idx_q + 4'd1;
`ifdef DS_SCRATCH_CRC_EN
            crc_d      = crc8_byte(crc_q, intf_rdata);
`endif
        end

        // Uses the _d byte values so a valid coinciding with completion is not missed.
        sample_ok = ({msb_d, lsb_d} != 16'hFFFF);
`ifdef DS_SCRATCH_CRC_EN
        sample_ok = sample_ok && (crc_d == 8'h00);
`endif

        unique case (state_q)
            StIdle: begin
                if (pending_q) begin
                    state_d    = StRst1;
                    phase_d    = PhIssue;
                    rd_cnt_d   = '0;
                    byte_idx_d = '0;
`ifdef DS_SCRATCH_CRC_EN
                    crc_d      = '0;
`endif
                end
            end
            StRst1:  if (cmd_done) state_d = StSkip1;
            StSkip1: if (cmd_done) state_d = StConv;
            StConv: begin
                if (cmd_done) begin
                    state_d    = StWaitConv;
                    conv_cnt_d = '0;
                end
            end
            StWaitConv: begin
                if (conv_cnt_q == CONV_LAST) begin
                    state_d = StRst2;
                end else begin
                    conv_cnt_d = conv_cnt_q + 32'd1;
                end
            end
            StRst2:  if (cmd_done) state_d = StSkip2;
            StSkip2: if (cmd_done) state_d = StRdsp;
            StRdsp:  if (cmd_done) state_d = StRead;
            StRead: begin
                if (cmd_done) begin
                    if (rd_cnt_q == LAST_BYTE) begin
`ifdef DS_SCRATCH_CRC_EN
                        state_d = StDone;
                        load    = 1'b1;
`else
                        state_d = StTerm;
`endif
                    end else begin
                        rd_cnt_d = rd_cnt_q + 4'd1;
                    end
                end
            end
            StTerm: begin
                if (cmd_done) begin
                    state_d = StDone;
                    load    = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Result registers change on entry to DONE so they are valid alongside temp_vld.
        if (load) begin
            ok_d = sample_ok;
            if (sample_ok) begin
                temp_raw_d = {msb_d, lsb_d};
                temp_neg_d = msb_d[7];
                temp_abs_d = msb_d[7] ? (~{msb_d[3:0], lsb_d} + 12'd1) : {msb_d[3:0], lsb_d};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            phase_q      <= PhIssue;
            period_cnt_q <= '0;
            conv_cnt_q   <= '0;
            pending_q    <= 1'b0;
            rd_cnt_q     <= '0;
            byte_idx_q   <= '0;
            lsb_q        <= '0;
            msb_q        <= '0;
            ok_q         <= 1'b0;
            temp_raw_q   <= '0;
            temp_abs_q   <= '0;
            temp_neg_q   <= 1'b0;
`ifdef DS_SCRATCH_CRC_EN
            crc_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            period_cnt_q <= period_cnt_d;
            conv_cnt_q   <= conv_cnt_d;
            pending_q    <= pending_d;
            rd_cnt_q     <= rd_cnt_d;
            byte_idx_q   <= byte_idx_d;
            lsb_q        <= lsb_d;
            msb_q        <= msb_d;
            ok_q         <= ok_d;
            temp_raw_q   <= temp_raw_d;
            temp_abs_q   <= temp_abs_d;
            temp_neg_q   <= temp_neg_d;
`ifdef DS_SCRATCH_CRC_EN
            crc_q        <= crc_d;
`endif
        end
    end

    always_comb begin
        intf_rst_en = 1'b0;
        intf_wr_en  = 1'b0;
        intf_rd_en  = 1'b0;
        intf_wdata  = 8'h00;
        unique case (state_q)
            StRst1, StRst2, StTerm: intf_rst_en = cmd_issue;
            StSkip1, StSkip2: begin
                intf_wr_en = cmd_issue;
                intf_wdata = 8'hCC;
            end
            StConv: begin
                intf_wr_en = cmd_issue;
                intf_wdata = 8'h44;
            end
            StRdsp: begin
                intf_wr_en = cmd_issue;
                intf_wdata = 8'hBE;
            end
            StRead:  intf_rd_en = cmd_issue;
            default: intf_wdata = 8'h00;
        endcase
    end

    assign temp_raw = temp_raw_q;
    assign temp_abs = temp_abs_q;
    assign temp_neg = temp_neg_q;
    assign temp_vld = (state_q == StDone) && ok_q;
    assign err      = (state_q == StDone) && !ok_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_ds_temp_sched.sv
// Bench for ds_temp_sched: behavioural byte-interface model plus result scoreboard.
`timescale 1ns/1ps
module tb_ds_temp_sched;

    localparam int unsigned PERIOD = 2000;
    localparam int unsigned CONV   = 500;
`ifdef DS_SCRATCH_CRC_EN
    localparam int NB = 9;
`else
    localparam int NB = 2;
`endif
    localparam int SEQ_LEN = (NB == 2) ? 9 : 15;
    localparam int C_RST = 256;
    localparam int C_WR  = 512;
    localparam int C_RD  = 768;

    typedef struct packed {
        logic        err;
        logic [15:0] raw;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        auto_en = 1'b0;
    logic        start = 1'b0;
    logic        intf_rst_en, intf_wr_en, intf_rd_en;
    logic [7:0]  intf_wdata;
    logic [7:0]  intf_rdata = 8'h00;
    logic        intf_rdata_vld = 1'b0;
    logic        intf_rdy = 1'b1;
    logic [15:0] temp_raw;
    logic [11:0] temp_abs;
    logic        temp_neg, temp_vld, busy, err;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    int n_done = 0;
    int n_cmds = 0;
    int n_rst = 0;
    int n44 = 0;
    int unsigned t44 = 0;
    logic [7:0] byte_q[$];
    exp_t exp_q[$];

    ds_temp_sched #(.PERIOD_CYC(PERIOD), .CONV_CYC(CONV)) dut (
        .clk(clk), .rst_n(rst_n), .auto_en(auto_en), .start(start),
        .intf_rst_en(intf_rst_en), .intf_wr_en(intf_wr_en), .intf_wdata(intf_wdata),
        .intf_rd_en(intf_rd_en), .intf_rdata(intf_rdata), .intf_rdata_vld(intf_rdata_vld),
        .intf_rdy(intf_rdy), .temp_raw(temp_raw), .temp_abs(temp_abs), .temp_neg(temp_neg),
        .temp_vld(temp_vld), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Dallas/Maxim 1-Wire CRC8: shift LSB first, feedback polynomial x^8+x^5+x^4+1.
    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 8'h8C) : (r >> 1);
        end
        return r;
    endfunction

    function automatic int exp_cmd(input int i);
        if (i == 0 || i == 3) return C_RST;
        if (i == 1 || i == 4) return C_WR + 8'hCC;
        if (i == 2) return C_WR + 8'h44;
        if (i == 5) return C_WR + 8'hBE;
        if (i < 6 + NB) return C_RD;
        return C_RST;
    endfunction

    // Queue the scratchpad bytes the model will return for one sample.
    task automatic queue_sample(input logic [7:0] b0, input logic [7:0] b1, input bit bad_crc);
        logic [7:0] v[8];
        logic [7:0] c;
        v[0] = b0; v[1] = b1; v[2] = 8'h4B; v[3] = 8'h46;
        v[4] = 8'h7F; v[5] = 8'hFF; v[6] = 8'h0C; v[7] = 8'h10;
        c = 8'h00;
        for (int i = 0; i < NB; i++) begin
            if (i < 8) begin
                byte_q.push_back(v[i]);
                c = crc8(c, v[i]);
            end else begin
                byte_q.push_back(c ^ {7'b0, bad_crc});
            end
        end
    endtask

    // Byte-interface model: checks command order, serves bytes, predicts results.
    initial begin : model
        int idx;
        int cmd;
        logic [7:0] b;
        logic [7:0] served[$];
        logic [7:0] c;
        exp_t e;
        idx = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                idx = 0;
                served.delete();
                continue;
            end
            if (!(intf_rst_en || intf_wr_en || intf_rd_en)) continue;
            check("one_cmd", 32'(intf_rst_en) + 32'(intf_wr_en) + 32'(intf_rd_en), 1);
            check("issue_when_rdy", 32'(intf_rdy), 1);
            cmd = intf_rst_en ? C_RST : (intf_wr_en ? C_WR + int'(intf_wdata) : C_RD);
            n_cmds++;
            if (cmd == C_RST) n_rst++;
            check("cmd_order", cmd, exp_cmd(idx));
            if (idx == 3) check("conv_gap_ok", 32'(cyc - t44 >= CONV), 1);
            @(posedge clk);
            #1 intf_rdy = 1'b0;
            repeat (19) @(posedge clk);
            if (cmd == C_RD) begin
                if (served.size() == 0 && byte_q.size() == 0) begin
                    if ($urandom_range(0, 5) == 0) queue_sample(8'hFF, 8'hFF, 1'b0);
                    else queue_sample(8'($urandom), 8'($urandom), $urandom_range(0, 5) == 0);
                end
                b = (byte_q.size() != 0) ? byte_q.pop_front() : 8'($urandom);
                served.push_back(b);
                #1 intf_rdata = b;
                intf_rdata_vld = 1'b1;
                @(posedge clk);
                #1 intf_rdata_vld = 1'b0;
                intf_rdy = 1'b1;
                if (served.size() == NB) begin
                    e.raw = {served[1], served[0]};
                    e.err = (e.raw == 16'hFFFF);
                    if (NB == 9) begin
                        c = 8'h00;
                        foreach (served[i]) c = crc8(c, served[i]);
                        if (c != 8'h00) e.err = 1'b1;
                    end
                    exp_q.push_back(e);
                    served.delete();
                end
            end else begin
                #1 intf_rdy = 1'b1;
                if (cmd == C_WR + 8'h44) begin
                    t44 = cyc;
                    n44++;
                end
            end
            idx = (idx + 1) % SEQ_LEN;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT reports a result.
    initial begin : monitor
        exp_t e;
        logic [15:0] last_raw;
        int v;
        int m;
        last_raw = 16'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_raw = 16'h0;
                continue;
            end
            if (temp_vld || err) begin
                n_done++;
                check("vld_err_exclusive", 32'(temp_vld && err), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'(temp_vld) + 32'(err), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("err_flag", 32'(err), 32'(e.err));
                    if (e.err) begin
                        check("raw_hold_on_err", 32'(temp_raw), 32'(last_raw));
                    end else begin
                        v = int'($signed(e.raw));
                        m = (v < 0) ? -v : v;
                        check("temp_raw", 32'(temp_raw), 32'(e.raw));
                        check("temp_neg", 32'(temp_neg), 32'(e.raw[15]));
                        check("temp_abs", 32'(temp_abs), 32'(m & 32'hFFF));
                        last_raw = e.raw;
                    end
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int prev, input string name);
        int k;
        k = 0;
        while (n_done == prev && k < 6000) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(k < 6000), 1);
    endtask

    task automatic check_zero_outputs(input string name);
        check(name, {intf_rst_en, intf_wr_en, intf_rd_en, intf_wdata, temp_raw, temp_vld, err},
              32'h0);
        check({name, "_b"}, {18'h0, temp_abs, temp_neg, busy}, 32'h0);
    endtask

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int prev;
        int base;
        int unsigned t0;
        int k;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset_outputs");
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_after_reset", {31'h0, busy}, 0);

        // 1: positive temperature
        queue_sample(8'h50, 8'h05, 1'b0);
        prev = n_done;
        pulse_start();
        wait_done(prev, "t1_done");
        check("t1_raw", 32'(temp_raw), 32'h0550);
        check("t1_abs_neg", {temp_neg, temp_abs}, 32'h0550);

        // 2: negative temperature
        queue_sample(8'h6F, 8'hFE, 1'b0);
        prev = n_done;
        pulse_start();
        wait_done(prev, "t2_done");
        check("t2_raw", 32'(temp_raw), 32'hFE6F);
        check("t2_abs_neg", {temp_neg, temp_abs}, 32'h1191);

        // 3: floating bus, result discarded
        queue_sample(8'hFF, 8'hFF, 1'b0);
        prev = n_done;
        pulse_start();
        wait_done(prev, "t3_done");
        @(negedge clk);
        check("t3_raw_kept", 32'(temp_raw), 32'hFE6F);

        // 4: periodic sampling with a start merged in mid-sample
        base = n_done;
        t0 = cyc;
        auto_en = 1'b1;
        prev = n44;
        k = 0;
        while (n44 == prev && k < 4000) begin
            @(negedge clk);
            k++;
        end
        check("t4_first_conv", 32'(k < 4000), 1);
        pulse_start();
        prev = n_done;
        wait_done(prev, "t4_done");
        prev = n_rst;
        k = 0;
        while (n_rst == prev && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("t4_back_to_back", 32'(k < 40), 1);
        while (cyc - t0 < 10000) @(negedge clk);
        check("t4_sample_count", 32'(n_done - base >= 5), 1);
        auto_en = 1'b0;
        repeat (3000) @(negedge clk);
        check("t4_drained", {31'h0, busy} + 32'(exp_q.size()), 0);

        // 5: reset during the conversion wait
        prev = n44;
        pulse_start();
        k = 0;
        while (n44 == prev && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("t5_reach_conv", 32'(k < 2000), 1);
        repeat (100) @(posedge clk);
        #3 rst_n = 1'b0;
        @(negedge clk);
        check_zero_outputs("t5_reset_outputs");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        prev = n_cmds;
        repeat (3000) @(negedge clk);
        check("t5_no_cmd", 32'(n_cmds), 32'(prev));
        check("t5_idle", {31'h0, busy}, 0);

`ifdef DS_SCRATCH_CRC_EN
        // 6: literal scratchpad image, then the same image with a corrupted CRC byte
        byte_q = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C};
        prev = n_done;
        pulse_start();
        wait_done(prev, "t6_good_done");
        check("t6_good_raw", 32'(temp_raw), 32'h0550);
        byte_q = '{8'h6F, 8'hFE, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1D};
        prev = n_done;
        pulse_start();
        wait_done(prev, "t6_bad_done");
        @(negedge clk);
        check("t6_bad_raw_kept", 32'(temp_raw), 32'h0550);
`endif
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
